battousai_store: RTL and testbench

Store-path partner of the load extension unit in the RV64 datapath: executes `sb`/`sh`/`sw`/`sd` (opcode 7'd35) as a read-modify-write on the 64-bit data memory. For `sb`/`sh`/`sw`, it reads the doubleword at the effective address, replaces the low 8/16/32 bits with the low bits of rs2, and writes the result back. `sd` writes rs2 directly. The control unit starts it with a one-cycle pulse and holds the pipeline until `done`.

---
 rtl/battousai_store_pkg.sv | 39 +++
 rtl/battousai_store_merge.sv | 27 ++
 rtl/battousai_store.sv | 102 ++++++++++
 tb/tb_battousai_store.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battousai_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battousai_store_pkg
// Description : Shared types and constants for the RV64 store unit.
//               The alignment helper is used when BATTOUSAI_STORE_MISALIGN_TRAP_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
package battousai_store_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_FIN   = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_STORE = 7'd35;

   localparam logic [2:0] SB = 3'd0;
   localparam logic [2:0] SH = 3'd1;
   localparam logic [2:0] SW = 3'd2;
   localparam logic [2:0] SD = 3'd3;

   function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] lsb);
      logic r;
      r = 1'b0;
      case (funct3)
         SH:      r = lsb[0];
         SW:      r = |lsb[1:0];
         SD:      r = |lsb[2:0];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/battousai_store_merge.sv
`default_nettype none
// ============================================================================
// Module      : battousai_store_merge
// Description : Combinational sub-word merge of store data into a read doubleword.
// Revision    : 1.0 - initial release
// ============================================================================
module battousai_store_merge
   import battousai_store_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [63:0] rs2,
   input  logic [63:0] rdata,
   output logic [63:0] merged
);

   always_comb begin
      merged = rs2;
      case (funct3)
         SB:      merged = {rdata[63:8],  rs2[7:0]};
         SH:      merged = {rdata[63:16], rs2[15:0]};
         SW:      merged = {rdata[63:32], rs2[31:0]};
         default: merged = rs2;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/battousai_store.sv
`default_nettype none
// ============================================================================
// Module      : battousai_store
// Description : RV64 sb/sh/sw/sd executor using read-modify-write on 64-bit memory.
//               Optional alignment trap: define BATTOUSAI_STORE_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module battousai_store
   import battousai_store_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] instr,
   input  logic [63:0] addr,
   input  logic [63:0] rs2_data,
   input  logic [63:0] mem_rdata,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_funct3;
   logic [63:0] r_addr;
   logic [63:0] r_rs2;
   logic [63:0] r_wdata;
   logic [63:0] w_merged;
   logic [2:0]  w_funct3;
   logic        w_accept;
   logic        w_trap;
   logic        w_unused_instr;

   assign w_funct3       = instr[14:12];
   assign w_accept       = (r_state == ST_IDLE) && start && (instr[6:0] == OPC_STORE);
   assign w_unused_instr = ^{instr[31:15], instr[11:7]};

`ifdef BATTOUSAI_STORE_MISALIGN_TRAP_EN
   assign w_trap = misaligned(w_funct3, addr[2:0]);
`else
   assign w_trap = 1'b0;
`endif

   battousai_store_merge u_merge (
      .funct3 (r_funct3),
      .rs2    (r_rs2),
      .rdata  (mem_rdata),
      .merged (w_merged)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_funct3[2] || w_trap) w_next = ST_ERR;
               else if (w_funct3 == SD)   w_next = ST_WRITE;
               else                       w_next = ST_READ;
            end
         end
         ST_READ:  w_next = ST_MERGE;
         ST_MERGE: w_next = ST_WRITE;
         ST_WRITE: w_next = ST_FIN;
         ST_FIN:   w_next = ST_IDLE;
         ST_ERR:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_funct3 <= 3'd0;
         r_addr   <= 64'd0;
         r_rs2    <= 64'd0;
         r_wdata  <= 64'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_funct3 <= w_funct3;
            r_addr   <= addr;
            r_rs2    <= rs2_data;
            // sd skips the read phase, so its data goes straight to the write register
            if (w_funct3 == SD) r_wdata <= rs2_data;
         end
         if (r_state == ST_MERGE) r_wdata <= w_merged;
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wr    = (r_state == ST_WRITE);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_FIN) || (r_state == ST_ERR);
   assign err       = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_battousai_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_battousai_store
// Description : Self-checking bench for battousai_store with a registered memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_battousai_store;
   import battousai_store_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] instr;
   logic [63:0] addr;
   logic [63:0] rs2_data;
   logic [63:0] mem_rdata;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wr;
   logic        busy;
   logic        done;
   logic        err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   battousai_store dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .instr     (instr),
      .addr      (addr),
      .rs2_data  (rs2_data),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   function automatic logic [63:0] mem_at(input logic [63:0] a);
      return (a == 64'h100) ? 64'h1122334455667788 : 64'h0F0E0D0C0B0A0908;
   endfunction

   always @(posedge clk) mem_rdata <= mem_at(mem_addr);

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
      return {17'd0, f3, 5'd0, opc};
   endfunction

   // Issues one start pulse and records what the DUT does over the next 12 cycles.
   task automatic do_store(input logic [31:0] iw, input logic [63:0] a, input logic [63:0] d,
                           input int rst_at, input int restart_at,
                           output int wr_cyc, output int wr_cnt, output logic [63:0] wdata,
                           output logic [63:0] waddr, output int done_cyc, output int done_cnt,
                           output logic err_seen, output logic [15:0] busy_tr);
      wr_cyc = 0; wr_cnt = 0; wdata = '0; waddr = '0;
      done_cyc = 0; done_cnt = 0; err_seen = 1'b0; busy_tr = '0;
      @(negedge clk);
      instr = iw; addr = a; rs2_data = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; instr = mk(SD, OPC_STORE); addr = '1; rs2_data = '1;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         busy_tr[c] = busy;
         if (mem_wr === 1'b1) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
               wr_cyc = c; wdata = mem_wdata; waddr = mem_addr;
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = c;
         end
         if (err === 1'b1) err_seen = 1'b1;
         reset = (c == rst_at);
         start = (c == restart_at);
         if (c == restart_at) begin
            instr = mk(SD, OPC_STORE); addr = 64'h200; rs2_data = 64'h5555AAAA5555AAAA;
         end
      end
      reset = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1; start = 1'b0; instr = '0; addr = '0; rs2_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({mem_addr, mem_wdata, mem_wr, busy, done, err} !== 132'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b, want all 0",
                  mem_addr, mem_wdata, mem_wr, busy, done, err);
      end
      @(negedge clk);
      reset = 1'b1; start = 1'b1; instr = mk(SB, OPC_STORE); addr = 64'h100; rs2_data = 64'hAB;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (busy !== 1'b0 || mem_wr !== 1'b0 || done !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL reset_with_start: got %0d active cycles, want 0", bad);
      end
   endtask

   task automatic test_sub_word(input string nm, input logic [2:0] f3, input logic [63:0] d,
                                input logic [63:0] want);
      int wc, wn, dc, dn; logic [63:0] wd, wa, ev; logic es; logic [15:0] bt;
      exp_q.push_back(want);
      do_store(mk(f3, OPC_STORE), 64'h100, d, 0, 0, wc, wn, wd, wa, dc, dn, es, bt);
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
      n_tests++;
      if (wn != 1 || wc != 3) begin
         n_fail++; $display("FAIL %s_write_cycle: got count=%0d cycle=%0d, want count=1 cycle=3", nm, wn, wc);
      end
      n_tests++;
      if (wd !== ev || wa !== 64'h100) begin
         n_fail++; $display("FAIL %s_wdata: got %h @%h, want %h @100", nm, wd, wa, ev);
      end
      n_tests++;
      if (dc != 4 || dn != 1 || es !== 1'b0 || bt !== 16'h001E) begin
         n_fail++; $display("FAIL %s_done: got done=%0d n=%0d err=%b busy=%h, want 4 1 0 001e", nm, dc, dn, es, bt);
      end
   endtask

   task automatic test_sd();
      int wc, wn, dc, dn; logic [63:0] wd, wa, ev; logic es; logic [15:0] bt;
      exp_q.push_back(64'h0123456789ABCDEF);
      do_store(mk(SD, OPC_STORE), 64'h100, 64'h0123456789ABCDEF, 0, 0, wc, wn, wd, wa, dc, dn, es, bt);
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
      n_tests++;
      if (wn != 1 || wc != 1 || wd !== ev) begin
         n_fail++; $display("FAIL sd_write: got n=%0d cyc=%0d wdata=%h, want 1 1 %h", wn, wc, wd, ev);
      end
      n_tests++;
      if (dc != 2 || dn != 1 || bt !== 16'h0006) begin
         n_fail++; $display("FAIL sd_done: got done=%0d n=%0d busy=%h, want 2 1 0006", dc, dn, bt);
      end
   endtask

   task automatic test_err();
      int wc, wn, dc, dn; logic [63:0] wd, wa; logic es; logic [15:0] bt;
      do_store(mk(3'd5, OPC_STORE), 64'h100, 64'h1, 0, 0, wc, wn, wd, wa, dc, dn, es, bt);
      n_tests++;
      if (dc != 1 || dn != 1 || es !== 1'b1 || wn != 0 || bt !== 16'h0002) begin
         n_fail++; $display("FAIL funct3_err: got done=%0d n=%0d err=%b wr=%0d busy=%h, want 1 1 1 0 0002",
                            dc, dn, es, wn, bt);
      end
      do_store(mk(SB, 7'd3), 64'h100, 64'h1, 0, 0, wc, wn, wd, wa, dc, dn, es, bt);
      n_tests++;
      if (bt !== 16'h0000 || dn != 0 || wn != 0 || es !== 1'b0) begin
         n_fail++; $display("FAIL bad_opcode: got busy=%h done=%0d wr=%0d err=%b, want 0 0 0 0", bt, dn, wn, es);
      end
   endtask

   task automatic test_reset_mid();
      int wc, wn, dc, dn; logic [63:0] wd, wa; logic es; logic [15:0] bt;
      do_store(mk(SB, OPC_STORE), 64'h100, 64'hAB, 2, 0, wc, wn, wd, wa, dc, dn, es, bt);
      n_tests++;
      if (wn != 0 || dn != 0 || bt !== 16'h0006) begin
         n_fail++; $display("FAIL reset_mid: got wr=%0d done=%0d busy=%h, want 0 0 0006", wn, dn, bt);
      end
      n_tests++;
      if (mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
         n_fail++; $display("FAIL reset_mid_regs: got addr=%h wdata=%h, want 0 0", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_busy_restart();
      int wc, wn, dc, dn; logic [63:0] wd, wa, ev; logic es; logic [15:0] bt;
      exp_q.push_back(64'h11223344556677AB);
      do_store(mk(SB, OPC_STORE), 64'h100, 64'hFFFFFFFFFFFFFFAB, 0, 2, wc, wn, wd, wa, dc, dn, es, bt);
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
      n_tests++;
      if (wn != 1 || wc != 3 || wd !== ev || wa !== 64'h100 || dn != 1) begin
         n_fail++; $display("FAIL busy_restart: got n=%0d cyc=%0d wdata=%h @%h done=%0d, want 1 3 %h @100 1",
                            wn, wc, wd, wa, dn, ev);
      end
   endtask

   task automatic test_misalign();
      int wc, wn, dc, dn; logic [63:0] wd, wa, ev, m; logic es; logic [15:0] bt;
      m = mem_at(64'h102);
`ifdef BATTOUSAI_STORE_MISALIGN_TRAP_EN
      do_store(mk(SW, OPC_STORE), 64'h102, 64'hDEADBEEF, 0, 0, wc, wn, wd, wa, dc, dn, es, bt);
      n_tests++;
      if (wn != 0 || dc != 1 || es !== 1'b1) begin
         n_fail++; $display("FAIL misalign_trap: got wr=%0d done=%0d err=%b, want 0 1 1", wn, dc, es);
      end
      ev = m;
`else
      exp_q.push_back({m[63:32], 32'hDEADBEEF});
      do_store(mk(SW, OPC_STORE), 64'h102, 64'hDEADBEEF, 0, 0, wc, wn, wd, wa, dc, dn, es, bt);
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
      n_tests++;
      if (wn != 1 || wc != 3 || wd !== ev || wa !== 64'h102 || es !== 1'b0) begin
         n_fail++; $display("FAIL misalign_write: got n=%0d cyc=%0d wdata=%h @%h err=%b, want 1 3 %h @102 0",
                            wn, wc, wd, wa, es, ev);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [63:0] ev;
      int wc;
      @(negedge clk);
      instr = mk(SD, OPC_STORE); addr = 64'h100; rs2_data = 64'h0A0B0C0D0E0F1011; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first_done: got %b, want 1", done);
      end
      @(posedge clk); #1;
      exp_q.push_back(64'h11223344DEADBEEF);
      instr = mk(SW, OPC_STORE); addr = 64'h100; rs2_data = 64'hDEADBEEF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wc = 0;
      for (int c = 1; c <= 6 && wc == 0; c++) begin
         if (mem_wr === 1'b1) wc = c;
         else begin
            @(posedge clk); #1;
         end
      end
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
      n_tests++;
      if (wc != 3 || mem_wdata !== ev) begin
         n_fail++; $display("FAIL b2b_second: got cyc=%0d wdata=%h, want 3 %h", wc, mem_wdata, ev);
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_sub_word("sb", SB, 64'hFFFFFFFFFFFFFFAB, 64'h11223344556677AB);
      test_sub_word("sh", SH, 64'h000000000000CDEF, 64'h112233445566CDEF);
      test_sub_word("sw", SW, 64'h00000000DEADBEEF, 64'h11223344DEADBEEF);
      test_sd();
      test_err();
      test_reset_mid();
      test_busy_restart();
      test_misalign();
      test_back_to_back();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
